// File: rtl/alu_matrix_pkg.sv
// Shared definitions for the 3x3 matrix ALU and its command sequencer.
// Element map: A at 0..8, B at 9..17, result at RES_BASE..RES_BASE+8.
package alu_matrix_pkg;

    localparam int         N_ELEM    = 9;
    localparam logic [4:0] RES_BASE  = 5'd18;
    localparam logic [5:0] SEL_NOP   = 6'h00;
    localparam logic [5:0] SEL_LOAD  = 6'h3F;
    localparam int         UNARY_BIT = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_RADDR,
        ST_RCAP,
        ST_RSEND
    } seq_state_e;

    // NOP and LOAD are reserved for the sequencer itself and cannot be compute ops.
    function automatic logic op_is_illegal(input logic [5:0] op);
        return (op == SEL_NOP) || (op == SEL_LOAD);
    endfunction

endpackage

// File: rtl/alu_matrix_seq_rdbuf.sv
// Result output register: captures one ALU element and holds it with
// valid/last until the consumer takes it.
module alu_matrix_seq_rdbuf #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cap,
    input  logic [DATA_W-1:0] cap_data,
    input  logic              cap_last,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    // Load on capture, drop valid/last once the handshake completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (cap) begin
            out_valid <= 1'b1;
            out_data  <= cap_data;
            out_last  <= cap_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_matrix_seq.sv
// Command sequencer for the 3x3 matrix ALU: loads operands, runs the op for a
// fixed number of cycles, then streams the 9 result elements out.
// Optional build macro ALU_MATRIX_SEQ_UNARY_EN: ops with cmd_op[4] set load A only.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for a command; illegal ops pulse err
// ST_LOAD    | writing operand elements into the ALU, one per handshake
// ST_COMPUTE | holding the op on alu_sel for COMPUTE_CYCLES cycles
// ST_RADDR   | presenting result address RES_BASE+k
// ST_RCAP    | capturing alu_ele_out into the output register
// ST_RSEND   | holding the result until out_ready
import alu_matrix_pkg::*;

module alu_matrix_seq #(
    parameter int DATA_W         = 32,
    parameter int COMPUTE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [5:0]        cmd_op,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              err,
    output logic              busy,
    output logic [4:0]        alu_ele_sel,
    output logic [5:0]        alu_sel,
    output logic [DATA_W-1:0] alu_ele_in,
    input  logic [DATA_W-1:0] alu_ele_out
);

    localparam int              CYC_W    = $clog2(COMPUTE_CYCLES + 1);
    localparam logic [CYC_W-1:0] CYC_LOAD = CYC_W'(COMPUTE_CYCLES - 1);
    localparam logic [4:0]      K_LAST   = 5'(N_ELEM - 1);
    localparam logic [4:0]      K_LAST2  = 5'(2 * N_ELEM - 1);

    seq_state_e       state, state_nxt;
    logic [4:0]       k, k_nxt;
    logic [CYC_W-1:0] cyc, cyc_nxt;
    logic [5:0]       op_q, op_nxt;
    logic             err_nxt;
    logic             cap;
    logic             unary;
    logic             load_last;

`ifdef ALU_MATRIX_SEQ_UNARY_EN
    assign unary = op_q[UNARY_BIT];
`else
    assign unary = 1'b0;
`endif

    assign load_last = (k == (unary ? K_LAST : K_LAST2));

    // State, element index, compute down-counter, latched op and err pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            k     <= '0;
            cyc   <= '0;
            op_q  <= SEL_NOP;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
            cyc   <= cyc_nxt;
            op_q  <= op_nxt;
            err   <= err_nxt;
        end
    end

    // Next-state and ALU bus drive; ALU writes happen only in the handshake cycle.
    always_comb begin
        state_nxt   = state;
        k_nxt       = k;
        cyc_nxt     = cyc;
        op_nxt      = op_q;
        err_nxt     = 1'b0;
        cap         = 1'b0;
        cmd_ready   = 1'b0;
        in_ready    = 1'b0;
        busy        = 1'b1;
        alu_sel     = SEL_NOP;
        alu_ele_sel = '0;
        alu_ele_in  = '0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    op_nxt = cmd_op;
                    k_nxt  = '0;
                    if (op_is_illegal(cmd_op)) err_nxt   = 1'b1;
                    else                       state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                in_ready    = 1'b1;
                alu_ele_sel = k;
                if (in_valid) begin
                    alu_sel    = SEL_LOAD;
                    alu_ele_in = in_data;
                    if (load_last) begin
                        k_nxt     = '0;
                        cyc_nxt   = CYC_LOAD;
                        state_nxt = ST_COMPUTE;
                    end else begin
                        k_nxt = k + 5'd1;
                    end
                end
            end
            ST_COMPUTE: begin
                alu_sel = op_q;
                if (cyc == '0) state_nxt = ST_RADDR;
                else           cyc_nxt   = cyc - CYC_W'(1);
            end
            ST_RADDR: begin
                alu_ele_sel = RES_BASE + k;
                state_nxt   = ST_RCAP;
            end
            ST_RCAP: begin
                alu_ele_sel = RES_BASE + k;
                cap         = 1'b1;
                state_nxt   = ST_RSEND;
            end
            ST_RSEND: begin
                alu_ele_sel = RES_BASE + k;
                if (out_ready) begin
                    if (k == K_LAST) begin
                        k_nxt     = '0;
                        state_nxt = ST_IDLE;
                    end else begin
                        k_nxt     = k + 5'd1;
                        state_nxt = ST_RADDR;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    alu_matrix_seq_rdbuf #(.DATA_W(DATA_W)) u_rdbuf (
        .clk       (clk),
        .reset     (reset),
        .cap       (cap),
        .cap_data  (alu_ele_out),
        .cap_last  (k == K_LAST),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last)
    );

endmodule

// File: doc/alu_matrix_seq.md
Name: alu_matrix_seq

Overview:
- Sequencer in front of the 3x3 matrix ALU datapath.
- Accepts one matrix command from a requester, then streams operand elements into the ALU element registers.
- Issues the compute op, waits a fixed latency, then streams the 9 result elements back out.
- Owns the ALU element-select, op-select and element-in buses exclusively; one command is in flight at a time.

Parameters:
- DATA_W, 32, element width.
- N_ELEM, 9, elements per matrix (3x3, row-major).
- RES_BASE, 18, element-select base address of result matrix (A at 0..8, B at 9..17).
- COMPUTE_CYCLES, 4, cycles alu_sel holds the op before results are readable (>=1).
- SEL_NOP, 6'h00, ALU op-select idle code.
- SEL_LOAD, 6'h3F, ALU op-select code that writes alu_ele_in into element alu_ele_sel.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  6  ALU op code for the command.
- in_valid  in  1  operand element valid.
- in_ready  out  1  operand element accepted when in_valid & in_ready.
- in_data  in  DATA_W  operand element (A row-major, then B).
- out_valid  out  1  result element valid.
- out_ready  in  1  result consumer ready.
- out_data  out  DATA_W  result element.
- out_last  out  1  high with result element 8.
- err  out  1  one-cycle pulse on illegal op.
- busy  out  1  high in any state except IDLE.
- alu_ele_sel  out  5  ALU element select.
- alu_sel  out  6  ALU op select.
- alu_ele_in  out  DATA_W  ALU element write data.
- alu_ele_out  in  DATA_W  ALU element read data, valid 1 cycle after alu_ele_sel changes.

Behaviour:
- Reset (async, any state):
  - state=IDLE, all counters 0.
  - All outputs 0 except cmd_ready=1.
  - alu_sel=SEL_NOP, alu_ele_sel=0, alu_ele_in=0.
  - An in-flight command is abandoned; no partial results are emitted.
- States: IDLE, LOAD, COMPUTE, RADDR, RCAP, RSEND.
- IDLE:
  - cmd_valid & cmd_ready latches cmd_op and clears elem counter k.
  - If cmd_op is SEL_NOP or SEL_LOAD: err pulses 1 cycle, stay IDLE, no ALU activity.
  - Otherwise go to LOAD.
- LOAD:
  - in_ready=1.
  - Each handshake drives alu_sel=SEL_LOAD, alu_ele_sel=k, alu_ele_in=in_data for exactly that cycle, then k++.
  - Non-handshake cycles drive alu_sel=SEL_NOP.
  - Operand count L=2*N_ELEM. After handshake L-1, k=0 and go to COMPUTE.
  - in_valid gaps simply stall.
- COMPUTE:
  - alu_sel=cmd_op for exactly COMPUTE_CYCLES cycles, counted by a cycle counter.
  - Then alu_sel=SEL_NOP and go to RADDR.
- RADDR: alu_ele_sel=RES_BASE+k; go to RCAP.
- RCAP: register alu_ele_out into out_data, assert out_valid, go to RSEND.
- RSEND:
  - out_data, out_valid and out_last are held stable until out_ready.
  - On handshake:
    - If k==N_ELEM-1: out_valid=0 and go to IDLE.
    - Else k++ and go to RADDR.
- Result throughput is at best 1 element per 3 cycles.
- out_last=(k==N_ELEM-1) while out_valid.
- cmd_valid outside IDLE is ignored (cmd_ready=0); cmd_op is not re-sampled.
- in_valid outside LOAD is ignored.
- alu_ele_sel is 5 bits; RES_BASE+N_ELEM-1 must be <=31.
- Minimum command latency, cmd accept to first out_valid: L + COMPUTE_CYCLES + 2 cycles with no stalls.

Optional Feature:
- Macro ALU_MATRIX_SEQ_UNARY_EN.
- Defined:
  - Ops with cmd_op[4]=1 are unary: L=N_ELEM, and only A (elements 0..8) is loaded.
  - B registers in the ALU are left untouched.
- Undefined:
  - cmd_op[4] has no sequencer meaning; L=2*N_ELEM for every legal op.

Decomposition:
- Shared package alu_matrix_pkg holds:
  - state enum;
  - SEL_NOP, SEL_LOAD, RES_BASE and N_ELEM constants;
  - the unary-op bit position.
- The ALU uses the same package.
- Sub-module alu_matrix_seq_rdbuf: the RCAP/RSEND output register with valid/ready hold.
- The FSM and counters stay in the top.

Test Plan:
- Legal op 6'h01 with COMPUTE_CYCLES=4; feed A=1..9, B=10..18 back-to-back:
  - alu_sel=3F on 18 consecutive cycles with alu_ele_sel 0..17;
  - then 01 for exactly 4 cycles;
  - 9 results are read from addresses 18..26, out_last on the 9th.
- out_ready held low 5 cycles on result 3 -> out_data/out_valid stable throughout; results remain in order.
- cmd_op=6'h00 and then 6'h3F -> err pulse each, busy stays 0, alu_sel never leaves 00.
- reset asserted during COMPUTE -> same-cycle (async) return to IDLE, alu_sel=00, cmd_ready=1; a new command then completes normally.
- in_valid toggling every other cycle during LOAD -> exactly 18 writes, each with the matching in_data, and none on idle cycles.
- With ALU_MATRIX_SEQ_UNARY_EN, cmd_op=6'h11 -> only 9 LOAD writes (addresses 0..8), then COMPUTE; without the macro -> 18 writes.
